pc_fetch_controller: RTL

Sequences the program counter for the fetch stage.
- Owns the PC register.
- Arbitrates redirect requests from the execute stage: jump, jump-register and taken branch.
- Holds the PC under pipeline stall or instruction-memory busy, and buffers a redirect that arrives while memory is busy.
- Emits a multi-cycle flush to squash younger instructions.
- Sits between the hazard unit, the instruction memory and the execute-stage target logic; its PC output drives the instruction-memory address.

---
 rtl/pc_fetch_controller_pkg.sv | 14 +
 rtl/pc_redirect_arbiter.sv | 31 +++
 rtl/pc_fetch_controller.sv | 126 ++++++++++++
 3 files changed

// File: rtl/pc_fetch_controller_pkg.sv
// Shared types and constants for the fetch-stage PC sequencer.
package pc_fetch_controller_pkg;

  localparam int unsigned XLEN = 32;
  localparam logic [XLEN-1:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_PEND = 2'd2,
    ST_TRAP = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/pc_redirect_arbiter.sv
// Fixed-priority redirect select (JUMP > JUMPREG > BRANCH) with alignment check.
module pc_redirect_arbiter
  import pc_fetch_controller_pkg::*;
(
  input  logic            jump_i,
  input  logic            jumpreg_i,
  input  logic            branch_i,
  input  logic [XLEN-1:0] jump_target_i,
  input  logic [XLEN-1:0] jumpreg_target_i,
  input  logic [XLEN-1:0] branch_target_i,
  output logic            redirect_o,
  output logic [XLEN-1:0] target_o,
  output logic            misaligned_o
);

  logic [XLEN-1:0] raw_target;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    raw_target = '0;
    if (jump_i)         raw_target = jump_target_i;
    else if (jumpreg_i) raw_target = jumpreg_target_i;
    else if (branch_i)  raw_target = branch_target_i;
  end

  assign redirect_o   = jump_i | jumpreg_i | branch_i;
  assign target_o     = {raw_target[XLEN-1:1], 1'b0};
  // Bit 0 is always dropped; a set bit 1 means the target is not word aligned.
  assign misaligned_o = redirect_o & raw_target[1];

endmodule

// File: rtl/pc_fetch_controller.sv
// Fetch-stage PC owner: advance, stall, redirect, busy-buffered redirect, flush and trap.
module pc_fetch_controller
  import pc_fetch_controller_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = DEFAULT_RESET_VECTOR,
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        STALL,
  input  logic        IMEM_BUSY,
  input  logic        JUMP,
  input  logic        JUMPREG,
  input  logic        BRANCH,
  input  logic [31:0] JUMP_TARGET,
  input  logic [31:0] JUMPREG_TARGET,
  input  logic [31:0] BRANCH_TARGET,
  output logic [31:0] PC,
  output logic [31:0] PC_PLUSFOUR,
  output logic        FETCH_VALID,
  output logic        FLUSH,
  output logic        MISALIGNED
);

  localparam logic [2:0] FLUSH_RELOAD = 3'(FLUSH_CYCLES);

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] pend_q, pend_d;
  logic [2:0]      flush_cnt_q, flush_cnt_d;
  logic            flush_q;
  logic            mis_q, mis_d;

  logic            redirect;
  logic [XLEN-1:0] target;
  logic            target_mis;

  pc_redirect_arbiter u_arbiter (
    .jump_i           (JUMP),
    .jumpreg_i        (JUMPREG),
    .branch_i         (BRANCH),
    .jump_target_i    (JUMP_TARGET),
    .jumpreg_target_i (JUMPREG_TARGET),
    .branch_target_i  (BRANCH_TARGET),
    .redirect_o       (redirect),
    .target_o         (target),
    .misaligned_o     (target_mis)
  );

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    pend_d      = pend_q;
    mis_d       = mis_q;
    flush_cnt_d = (flush_cnt_q != 3'd0) ? flush_cnt_q - 3'd1 : flush_cnt_q;

    unique case (state_q)
      ST_BOOT: state_d = ST_RUN;
      ST_RUN: begin
        if (redirect) begin
          if (target_mis) begin
            mis_d   = 1'b1;
            state_d = ST_TRAP;
          end else begin
            flush_cnt_d = FLUSH_RELOAD;
            if (IMEM_BUSY) begin
              pend_d  = target;
              state_d = ST_PEND;
            end else begin
              pc_d = target;  // redirect wins over STALL
            end
          end
        end else if (!STALL && !IMEM_BUSY) begin
          pc_d = pc_q + 32'd4;
        end
      end
      ST_PEND: begin
        if (redirect) begin
          if (target_mis) begin
            mis_d   = 1'b1;
            state_d = ST_TRAP;
          end else begin
            flush_cnt_d = FLUSH_RELOAD;
            if (IMEM_BUSY) begin
              pend_d = target;
            end else begin
              pc_d    = target;
              state_d = ST_RUN;
            end
          end
        end else if (!IMEM_BUSY) begin
          pc_d    = pend_q;
          state_d = ST_RUN;
        end
      end
      ST_TRAP: ;  // frozen until reset; flush counter still drains
      default: state_d = ST_BOOT;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state_q     <= ST_BOOT;
      pc_q        <= RESET_VECTOR;
      pend_q      <= '0;
      flush_cnt_q <= '0;
      flush_q     <= 1'b0;
      mis_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      pend_q      <= pend_d;
      flush_cnt_q <= flush_cnt_d;
      flush_q     <= (flush_cnt_d != 3'd0);
      mis_q       <= mis_d;
    end
  end

  assign PC          = pc_q;
  assign PC_PLUSFOUR = pc_q + 32'd4;
  assign FETCH_VALID = (state_q == ST_RUN);
  assign FLUSH       = flush_q;
  assign MISALIGNED  = mis_q;

endmodule
